// File: rtl/conv_engine_pkg.sv
// Shared codes, widths and tap helpers for the convolution engine.
package conv_engine_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned PROD_W = 2 * BYTE_W;

  // Memory command codes driven on the state port
  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_CALC  = 2'b10;
  localparam logic [1:0] CMD_IDLE  = 2'b11;

  // Memory status codes received on MS
  localparam logic [1:0] MS_CLEARED  = 2'b01;
  localparam logic [1:0] MS_LOADED   = 2'b10;
  localparam logic [1:0] MS_CAPTURED = 2'b11;

  // Engine status codes driven on CS
  localparam logic [1:0] CS_NONE  = 2'b00;
  localparam logic [1:0] CS_VALID = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_CALC,
    ST_DONE
  } fsm_t;

  typedef struct packed {
    logic [1:0] u;
    logic [1:0] v;
  } tap_t;

  // Split a 3x3 tap index t = u*3+v into its row/column
  function automatic tap_t tap_split(input logic [3:0] t);
    tap_t r;
    if (t < 4'd3) begin
      r.u = 2'd0;
      r.v = t[1:0];
    end else if (t < 4'd6) begin
      r.u = 2'd1;
      r.v = 2'(t - 4'd3);
    end else begin
      r.u = 2'd2;
      r.v = 2'(t - 4'd6);
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_engine_mac.sv
// Multiply-accumulate with a saturated, byte-scaled view of the running sum.
module conv_mac
  import conv_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [BYTE_W-1:0] d,
  input  logic [BYTE_W-1:0] f,
  output logic [BYTE_W-1:0] sat_c
);

  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]  sum_c;
  logic [ACC_W-1:0]  shr_c;

  // Next accumulator value (restarts on the first tap) and its saturated >>8
  always_comb begin
    prod_c = PROD_W'(d) * PROD_W'(f);
    sum_c  = (first ? '0 : acc) + ACC_W'(prod_c);
    shr_c  = sum_c >> BYTE_W;
    sat_c  = (|shr_c[ACC_W-1:BYTE_W]) ? '1 : shr_c[BYTE_W-1:0];
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/conv_engine.sv
// Job sequencer: memory handshake, 3x3 convolution and 2x2 max-pool over a 4x4 tile.
module conv_engine
  import conv_engine_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          MS,
  input  logic [16*BYTE_W-1:0] DATA,
  input  logic [9*BYTE_W-1:0]  FILTER,
  output logic [1:0]          state,
  output logic [1:0]          CS,
  output logic [4*BYTE_W-1:0] inret22,
  output logic [4*BYTE_W-1:0] inret33,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  fsm_t              fsm;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        o;
  logic [3:0]        t;
  logic [BYTE_W-1:0] pmax;

  tap_t              tap_c;
  logic [1:0]        row_c;
  logic [1:0]        col_c;
  logic [BYTE_W-1:0] d_c;
  logic [BYTE_W-1:0] f_c;
  logic [BYTE_W-1:0] p_c;
  logic [BYTE_W-1:0] mx_c;
  logic [BYTE_W-1:0] sat_c;
  logic              wait_expired_c;

  // Operand and pool-element selection for the current (o, t)
  always_comb begin
    tap_c          = tap_split(t);
    row_c          = 2'(o[1]) + tap_c.u;
    col_c          = 2'(o[0]) + tap_c.v;
    d_c            = DATA[{row_c, col_c, 3'b000} +: BYTE_W];
    f_c            = FILTER[{t, 3'b000} +: BYTE_W];
    p_c            = DATA[{o[1], t[1], o[0], t[0], 3'b000} +: BYTE_W];
    mx_c           = ((t == 4'd0) || (p_c > pmax)) ? p_c : pmax;
    wait_expired_c = (wait_cnt == WAIT_LAST);
  end

  conv_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .en    (fsm == ST_CALC),
    .first (t == 4'd0),
    .d     (d_c),
    .f     (f_c),
    .sat_c (sat_c)
  );

  // Engine FSM with registered command/status/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= ST_IDLE;
      state    <= CMD_IDLE;
      CS       <= CS_NONE;
      inret22  <= '0;
      inret33  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
      o        <= '0;
      t        <= '0;
      pmax     <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            fsm      <= ST_CLEAR;
            state    <= CMD_CLEAR;
            CS       <= CS_NONE;
            busy     <= 1'b1;
            err      <= 1'b0;
            inret22  <= '0;
            inret33  <= '0;
            wait_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (MS == MS_CLEARED) begin
            fsm      <= ST_LOAD;
            state    <= CMD_LOAD;
            wait_cnt <= '0;
          end else if (wait_expired_c) begin
            fsm   <= ST_IDLE;
            state <= CMD_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_LOAD: begin
          if (MS == MS_LOADED) begin
            fsm   <= ST_CALC;
            state <= CMD_CALC;
            CS    <= CS_NONE;
            o     <= '0;
            t     <= '0;
          end else if (wait_expired_c) begin
            fsm   <= ST_IDLE;
            state <= CMD_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_CALC: begin
          if (t <= 4'd3) begin
            pmax <= mx_c;
          end
          if (t == 4'd3) begin
            inret22[{o, 3'b000} +: BYTE_W] <= mx_c;
          end
          if (t == 4'd8) begin
            inret33[{o, 3'b000} +: BYTE_W] <= sat_c;
            t <= '0;
            if (o == 2'd3) begin
              fsm      <= ST_DONE;
              CS       <= CS_VALID;
              wait_cnt <= '0;
            end else begin
              o <= o + 2'd1;
            end
          end else begin
            t <= t + 4'd1;
          end
        end
        ST_DONE: begin
          if (MS == MS_CAPTURED) begin
            fsm   <= ST_IDLE;
            state <= CMD_IDLE;
            CS    <= CS_NONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wait_expired_c) begin
            fsm   <= ST_IDLE;
            state <= CMD_IDLE;
            CS    <= CS_NONE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          fsm   <= ST_IDLE;
          state <= CMD_IDLE;
          CS    <= CS_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine with a responsive memory model.
module tb_conv_engine;

  localparam int unsigned TO = 15;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   MS;
  logic [127:0] DATA;
  logic [71:0]  FILTER;
  logic [1:0]   state;
  logic [1:0]   CS;
  logic [31:0]  inret22;
  logic [31:0]  inret33;
  logic         busy;
  logic         done;
  logic         err;

  logic mem_en;
  logic hold_done;

  int tests;
  int fails;

  conv_engine #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .MS      (MS),
    .DATA    (DATA),
    .FILTER  (FILTER),
    .state   (state),
    .CS      (CS),
    .inret22 (inret22),
    .inret33 (inret33),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal memory: answers each command on the following edge
  always @(negedge clk) begin
    if (!mem_en) MS = 2'b00;
    else if (state == 2'b00) MS = 2'b01;
    else if (state == 2'b01) MS = 2'b10;
    else if (state == 2'b10 && CS == 2'b01 && !hold_done) MS = 2'b11;
    else MS = 2'b00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Observe a bounded window after a start pulse
  task automatic watch(input int cycles, output int calc_n, output int done_n, output int valid_n);
    calc_n = 0; done_n = 0; valid_n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (state == 2'b10 && CS == 2'b00 && busy) calc_n++;
      if (CS == 2'b01) valid_n++;
      if (done) done_n++;
    end
  endtask

  int  calc_n, done_n, valid_n;
  logic seen;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; mem_en = 1'b0; hold_done = 1'b0;
    DATA = '0; FILTER = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'h3);
    chk("rst_cs", 32'(CS), 32'h0);
    chk("rst_inret22", inret22, 32'h0);
    chk("rst_inret33", inret33, 32'h0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'h0);
    rst = 1'b0;
    mem_en = 1'b1;

    // Reference tile: saturating convolution everywhere
    DATA   = 128'hEBE9BBF1_F1499052_AED66CE1_84BE2329;
    FILTER = 72'h24993E0C873CDBA6B3;
    pulse_start();
    watch(60, calc_n, done_n, valid_n);
    chk("ref_inret22", inret22, 32'hF1F1D6E1);
    chk("ref_inret33", inret33, 32'hFFFFFFFF);
    chk("ref_done_cnt", 32'(done_n), 32'd1);
    chk("ref_calc_len", 32'(calc_n), 32'd36);
    chk("ref_valid_len", 32'(valid_n), 32'd1);
    chk("ref_idle", {28'd0, state, busy, err}, 32'hC);

    // Ramp tile with asymmetric filter: exercises indexing, no saturation
    DATA   = 128'hF0E0D0C0_B0A09080_70605040_30201000;
    FILTER = 72'h090807060504030201;
    pulse_start();
    watch(60, calc_n, done_n, valid_n);
    chk("ramp_inret22", inret22, 32'hF0D07050);
    chk("ramp_inret33", inret33, 32'h211E1512);
    chk("ramp_done_cnt", 32'(done_n), 32'd1);

    // Uniform tile
    DATA   = {16{8'h10}};
    FILTER = {9{8'h10}};
    pulse_start();
    watch(60, calc_n, done_n, valid_n);
    chk("flat_inret22", inret22, 32'h10101010);
    chk("flat_inret33", inret33, 32'h09090909);
    chk("flat_calc_len", 32'(calc_n), 32'd36);
    repeat (3) @(posedge clk);
    #1 chk("flat_hold", inret33, 32'h09090909);

    // Silent memory: timeout out of CLEAR
    mem_en = 1'b0;
    pulse_start();
    done_n = 0;
    for (int k = 1; k <= int'(TO); k++) begin
      @(posedge clk); #1;
      if (done) done_n++;
      if (k == int'(TO) - 1) chk("to_err_early", {30'd0, busy, err}, 32'h2);
    end
    chk("to_err", 32'(err), 32'd1);
    chk("to_idle", {29'd0, state, busy}, 32'h6);
    chk("to_cleared", inret33, 32'h0);
    chk("to_no_done", 32'(done_n), 32'd0);
    mem_en = 1'b1;

    // Reset in the middle of CALC
    pulse_start();
    @(posedge clk); #1;
    chk("mid_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
    repeat (21) @(negedge clk);
    chk("mid_in_calc", {28'd0, state, CS}, 32'h8);
    chk("mid_partial22", inret22, 32'h00001010);
    chk("mid_partial33", inret33, 32'h00000909);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cmd", {28'd0, state, CS}, 32'hC);
    chk("mid_rst_res", inret22 | inret33, 32'h0);
    chk("mid_rst_flags", {29'd0, busy, done, err}, 32'h0);
    @(negedge clk) rst = 1'b0;
    pulse_start();
    watch(60, calc_n, done_n, valid_n);
    chk("mid_fresh_33", inret33, 32'h09090909);
    chk("mid_fresh_done", 32'(done_n), 32'd1);

    // start during CALC and during DONE is ignored
    DATA   = 128'hF0E0D0C0_B0A09080_70605040_30201000;
    FILTER = 72'h090807060504030201;
    hold_done = 1'b1;
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (CS == 2'b01) seen = 1'b1;
    end
    chk("ign_reach_done", 32'(seen), 32'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ign_still_done", {29'd0, CS, busy}, 32'h3);
    hold_done = 1'b0;
    watch(20, calc_n, done_n, valid_n);
    chk("ign_done_cnt", 32'(done_n), 32'd1);
    chk("ign_no_restart", {29'd0, state, busy}, 32'h6);
    chk("ign_result", inret33, 32'h211E1512);

    // start together with reset resolves to reset
    @(negedge clk) begin start = 1'b1; rst = 1'b1; end
    @(posedge clk); #1;
    chk("sr_idle", {29'd0, state, busy}, 32'h6);
    @(negedge clk) begin start = 1'b0; rst = 1'b0; end
    @(posedge clk); #1;
    chk("sr_no_start", {29'd0, state, busy}, 32'h6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have clk, input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1 bit, reset, synchronous, active-high.
REQ-003 SHALL have start, input, 1 bit; a one-cycle request to run one job, accepted only in IDLE.
REQ-004 SHALL have MS, input, 2 bits, memory status: 01 cleared, 10 loaded, 11 results captured.
REQ-005 SHALL have DATA, input, 128 bits; 4x4 unsigned bytes, byte index r*4+c = D[r][c].
REQ-006 SHALL have FILTER, input, 72 bits; 3x3 unsigned bytes, byte index r*3+c = F[r][c].
REQ-007 SHALL have state, output, 2 bits, memory command: 00 clear, 01 load, 10 calc/write-back, 11 idle.
REQ-008 SHALL have CS, output, 2 bits, engine status: 00 busy/none, 01 results valid.
REQ-009 SHALL have inret22, output, 32 bits; 2x2 max-pool result, byte r*2+c.
REQ-010 SHALL have inret33, output, 32 bits; 2x2 result of the 3x3 convolution, byte r*2+c.
REQ-011 SHALL have busy, done and err outputs, 1 bit each: job active, one-cycle completion pulse, and sticky handshake timeout.
REQ-012 SHALL use parameter TIMEOUT, default 15: maximum cycles to wait for any MS response.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, LOAD, CALC, DONE; all outputs registered.
REQ-014 IDLE SHALL drive state=11 and CS=00; on start it SHALL go to CLEAR next cycle, clearing err and both result registers.
REQ-015 CLEAR SHALL drive state=00 and go to LOAD in the cycle after MS==01 is sampled.
REQ-016 LOAD SHALL drive state=01 and go to CALC in the cycle after MS==10 is sampled; DATA/FILTER SHALL then be treated as stable.
REQ-017 CALC SHALL drive state=10 and CS=00, and SHALL last exactly 36 cycles: output index o=0..3 (o=i*2+j), tap t=0..8 (t=u*3+v), with t incrementing fastest.
REQ-018 Each CALC cycle SHALL perform one MAC: acc += D[i+u][j+v]*F[u][v]; acc is 20-bit unsigned and zeroed at t=0.
REQ-019 At t=8, inret33 byte o SHALL be written with min(final acc >> 8, 255), i.e. saturated, never wrapped.
REQ-020 For t=0..3 of output o, the engine SHALL update a running max of D[2i+t/2][2j+t%2]; at t=3 inret22 byte o SHALL be written with the max.
REQ-021 After o=3,t=8 the engine SHALL enter DONE, driving state=10 and CS=01 with inret22/inret33 held stable.
REQ-022 DONE SHALL go to IDLE in the cycle after MS==11 is sampled, pulse done for one cycle and drop CS to 00.
REQ-023 Each of CLEAR, LOAD and DONE SHALL run a wait counter; after TIMEOUT cycles without the expected MS, the engine SHALL set err and go to IDLE with no done pulse.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-026 start and rst asserted together SHALL resolve to reset.
REQ-027 Result registers SHALL keep their last values in IDLE until the next accepted start.

Reset
REQ-028 On rst the engine SHALL enter IDLE with state=11, CS=00, inret22=0, inret33=0, busy=0, done=0, err=0, and acc, counters and running max all zero.
REQ-029 rst in any state, including mid-CALC, SHALL abandon the job in the next cycle; no partial results SHALL be retained.

Structure
REQ-030 A shared package SHALL hold the state command codes (00/01/10/11), the MS and CS codes, the FSM state enum, and the widths 8 and 20.
REQ-031 The MAC/accumulator with saturation SHALL be one sub-module, conv_mac; the FSM, indexing and pooling stay in conv_engine.

Verification
REQ-032 D = {41,35,190,132 / 225,108,214,174 / 82,144,73,241 / 241,187,233,235}, F = {179,166,219 / 60,135,12 / 62,153,36}, with an ideal memory model -> inret22 bytes = 225,214,241,241; inret33 byte0 = 255 (acc 115151 saturates); one done pulse.
REQ-033 DATA all 16, FILTER all 16 -> every inret33 byte = 9 and every inret22 byte = 16; CALC lasts exactly 36 cycles.
REQ-034 MS held at 00 after start -> err=1 exactly TIMEOUT cycles after entering CLEAR, engine back in IDLE, no done pulse.
REQ-035 rst at CALC cycle 20 -> next cycle all outputs at reset values; a fresh start then completes normally.
REQ-036 start pulsed during CALC and DONE -> ignored, exactly one done pulse; start and rst in the same cycle -> engine stays in IDLE.
